// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier core with sign application.
// WIDTH shift-add iterations, then optional two's-complement negate and a done pulse.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand_abs,
  input  logic [WIDTH-1:0]     mplier_abs,
  input  logic                 sign,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == LAST) state_d = S_SIGN;
      S_SIGN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state; start outside IDLE is simply not looked at.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mcand_abs};
          mplier_d = mplier_abs;
          sign_d   = sign;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
      end
      S_SIGN: begin
        // Negating a zero accumulator wraps back to zero, so no negative zero.
        product_d = sign_q ? (~acc_q + ONE) : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed plus randomized bench for shift_add_multiplier.
// Expected products come from plain signed arithmetic on the operand magnitudes.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand_abs;
  logic [7:0]  mplier_abs;
  logic        sign;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int          errors;
  int          checks;
  logic [15:0] prev_product;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mcand_abs  (mcand_abs),
    .mplier_abs (mplier_abs),
    .sign       (sign),
    .product    (product),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    if (s) p = 32'd0 - p;
    return p[15:0];
  endfunction

  // One full operation from a start pulse; leaves the bench in the done-high cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [15:0] exp;
    bit          run_ok;
    exp = model(a, b, s);
    mcand_abs  = a;
    mplier_abs = b;
    sign       = s;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    mcand_abs  = 8'($urandom);
    mplier_abs = 8'($urandom);
    sign       = 1'($urandom);
    run_ok = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      if (busy !== 1'b1 || done !== 1'b0 || product !== prev_product) run_ok = 1'b0;
      tick();
    end
    check({tag, "_run"}, 32'(run_ok), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_prod"}, 32'(product), 32'(exp));
    $display("op %s: %0d x %0d sign=%0d -> product=%h (model %h)", tag, a, b, s, product, exp);
    prev_product = exp;
  endtask

  initial begin
    int dones;
    bit busy_ok;
    errors       = 0;
    checks       = 0;
    prev_product = 16'h0000;
    rst          = 1'b1;
    start        = 1'b0;
    mcand_abs    = 8'd0;
    mplier_abs   = 8'd0;
    sign         = 1'b0;
    #23;
    check("reset_prod", 32'(product), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    run_op(8'd12, 8'd11, 1'b0, "pos_12x11");
    check("pos_value", 32'(product), 32'h0084);
    tick();
    check("done_clears", 32'(done), 32'h0);

    run_op(8'h80, 8'h7F, 1'b1, "neg_80x7f");
    check("neg_value", 32'(product), 32'hC080);
    tick();
    run_op(8'h80, 8'h80, 1'b0, "pos_80x80");
    check("max_value", 32'(product), 32'h4000);
    tick();
    run_op(8'h00, 8'hFF, 1'b1, "zero_neg");
    tick();

    // Start while busy and operand changes during the run.
    mcand_abs = 8'd7; mplier_abs = 8'd9; sign = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; mcand_abs = 8'd3; mplier_abs = 8'd3; sign = 1'b0;
    tick();
    mcand_abs = 8'd50; mplier_abs = 8'd50;
    tick();
    start = 1'b0;
    dones   = 0;
    busy_ok = 1'b1;
    for (int n = 5; n <= 14; n++) begin
      if (n < 9 && busy !== 1'b1) busy_ok = 1'b0;
      if (n > 9 && busy !== 1'b0) busy_ok = 1'b0;
      if (done === 1'b1) dones++;
      if (n == 9) check("busy_start_done", 32'(done), 32'h1);
      tick();
    end
    check("busy_start_pulses", 32'(dones), 32'd1);
    check("busy_start_busy", 32'(busy_ok), 32'd1);
    check("busy_start_prod", 32'(product), 32'(model(8'd7, 8'd9, 1'b1)));
    check("busy_start_lit", 32'(product), 32'hFFC1);
    $display("op busy_start: 7 x 9 sign=1 -> product=%h dones=%0d", product, dones);
    prev_product = 16'hFFC1;

    // Back-to-back: second start issued in the done cycle.
    run_op(8'd10, 8'd10, 1'b0, "b2b_first");
    run_op(8'd2, 8'd3, 1'b1, "b2b_second");
    check("b2b_value", 32'(product), 32'hFFFA);
    tick();

    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom), "rand");
      if (($urandom & 1) != 0) tick();
    end

    // Reset mid-run: abort, product reads 0 at once.
    mcand_abs = 8'd25; mplier_abs = 8'd3; sign = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_prod", 32'(product), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    $display("op midrst: reset during 25 x 3 -> product=%h busy=%0d", product, busy);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_busy", 32'(busy), 32'h0);
    prev_product = 16'h0000;
    run_op(8'd5, 8'd6, 1'b0, "after_rst");
    check("after_rst_value", 32'(product), 32'h001E);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
